count_check: RTL

- Receiving end of the counter output bus: samples a WIDTH-bit count every enabled clock and verifies it advances by exactly +1 modulo 2^WIDTH.
- Acquires lock after LOCK_N consecutive good increments.
- While locked, flags sequence errors and wrap-arounds and keeps a saturating error tally.
- Sits downstream of the count block, on-chip or in benches, as a self-checking monitor.

---
 rtl/count_pkg.sv | 12 +
 rtl/sat_count.sv | 18 +
 rtl/count_check.sv | 95 +++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the count_check monitor: FSM state encoding and bus width default.
package count_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

endpackage

// File: rtl/sat_count.sv
// Saturating up-counter: advances on inc and sticks at all-ones.
module sat_count import count_pkg::*; #(
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [ERR_W-1:0] cnt
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + ERR_W'(1);
    end

endmodule

// File: rtl/count_check.sv
// Checks that an observed count advances by exactly +1 (mod 2^WIDTH) each enabled cycle,
// locks after LOCK_N good steps and reports errors and wraps while locked.
module count_check import count_pkg::*; #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LOCK_N = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] count,
    output logic             locked,
    output logic             error,
    output logic             wrap,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] last
);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_inc;
    logic [3:0]       good_cnt;
    logic [3:0]       good_inc;
    logic             good;
    logic             err_hit;

    // The increment is kept WIDTH bits wide so max -> 0 counts as good.
    assign prev_inc = prev + WIDTH'(1);
    assign good     = (count == prev_inc);
    assign good_inc = good_cnt + 4'd1;
    assign err_hit  = en && (state == ST_LOCK) && !good;
    assign last     = prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            prev     <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
            error    <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            error <= 1'b0;
            wrap  <= 1'b0;
            if (en) begin
                case (state)
                    ST_IDLE: begin
                        prev     <= count;
                        good_cnt <= '0;
                        state    <= ST_SYNC;
                    end
                    ST_SYNC: begin
                        prev <= count;
                        if (good) begin
                            good_cnt <= good_inc;
                            if (good_inc == 4'(LOCK_N)) begin
                                state  <= ST_LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    ST_LOCK: begin
                        prev <= count;
                        if (good) begin
                            wrap <= (prev == '1);
                        end else begin
                            // The bad sample doubles as the first sample of resync.
                            error    <= 1'b1;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            state    <= ST_SYNC;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end else if (state != ST_IDLE && state != ST_SYNC && state != ST_LOCK) begin
                state  <= ST_IDLE;
                locked <= 1'b0;
            end
        end
    end

    sat_count #(.ERR_W(ERR_W)) u_err (
        .clock (clock),
        .reset (reset),
        .inc   (err_hit),
        .cnt   (err_count)
    );

endmodule
